// File: rtl/xgs_pkg.sv
// Shared types for the XGS pixel-path stages.
//   state_e      : line packer FSM state
//   fifo_entry_t : one buffered output word with its stream markers
//   OUT_BYTES    : bytes per packed output word
package xgs_pkg;

  localparam int unsigned OUT_BYTES = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLowHalf,
    StHighHalf
  } state_e;

  typedef struct packed {
    logic [OUT_BYTES*8-1:0] tdata;
    logic                   tuser;
    logic                   tlast;
  } fifo_entry_t;

endpackage

// File: rtl/xgs_sync_fifo.sv
// Parameterised single-clock FIFO with full/empty flags.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_en_i/wr_data_i : write request; a write is taken when not full or when a read happens
//                       in the same cycle
//   rd_en_i       : pop the head entry (ignored when empty)
//   rd_data_o     : head entry, registered storage (no combinational path from rd_en_i)
//   full_o/empty_o: occupancy flags
// Depth must be a power of two, at least 2.
module xgs_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == (PtrW+1)'(Depth));
  assign empty_o   = (count_q == '0);
  assign do_rd     = rd_en_i & ~empty_o;
  assign do_wr     = wr_en_i & (~full_o | do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/xgs_line_packer.sv
// XGS line packer: keeps the 8 MSBs of each decoded pixel, packs two 4-pixel beats into one
// 64-bit AXI-stream word (tuser = start of frame, tlast = end of line), checks line length
// and buffers words in a small FIFO against DMA backpressure.
// Ports:
//   sclk, sclk_reset_n            : pixel clock, asynchronous active-low reset
//   cfg_enable, cfg_line_pix      : packer enable, expected pixels per line
//   pix_valid/data/sof/eol/eof    : decoded pixel beats (no backpressure)
//   m_axis_*                      : packed output stream
//   stat_overflow, stat_len_err   : sticky error flags, cleared by stat_clr (set wins)
// Optional build macro XGS_LINE_PACKER_STATS_EN adds stat_frame_cnt and stat_line_cnt.
module xgs_line_packer
  import xgs_pkg::*;
#(
  parameter int unsigned PIX_W      = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LPIX_W     = 13
) (
  input  logic                sclk,
  input  logic                sclk_reset_n,
  input  logic                cfg_enable,
  input  logic [LPIX_W-1:0]   cfg_line_pix,
  input  logic                pix_valid,
  input  logic [4*PIX_W-1:0]  pix_data,
  input  logic                pix_sof,
  input  logic                pix_eol,
  input  logic                pix_eof,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [63:0]         m_axis_tdata,
  output logic                m_axis_tuser,
  output logic                m_axis_tlast,
  output logic                stat_overflow,
  output logic                stat_len_err,
  input  logic                stat_clr
`ifdef XGS_LINE_PACKER_STATS_EN
  ,
  output logic [15:0]         stat_frame_cnt,
  output logic [LPIX_W-1:0]   stat_line_cnt
`endif
);

  localparam int unsigned EntryW = $bits(fifo_entry_t);

  state_e            state_q, state_d;
  logic [31:0]       beat_bytes;
  logic [31:0]       low_bytes_q, low_bytes_d;
  logic              low_user_q, low_user_d;
  logic [LPIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [LPIX_W-1:0] cnt_base, cnt_beat;
  logic [LPIX_W:0]   cnt_sum;
  logic              overflow_q, overflow_d, len_err_q, len_err_d;
  logic              start, restart, abort, low_beat, high_beat;
  logic              push, pop, len_bad, fifo_full, fifo_empty;
  fifo_entry_t       push_entry, head_entry;
  logic [EntryW-1:0] fifo_rdata;
  logic              unused_pix;

  always_comb begin
    beat_bytes = '0;
    for (int k = 0; k < 4; k++) begin
      beat_bytes[k*8 +: 8] = pix_data[k*PIX_W + PIX_W - 8 +: 8];
    end
  end
  // Pixel LSBs are intentionally discarded.
  assign unused_pix = ^pix_data;

  // Beat classification. A sof outside IDLE restarts the frame; with the packer disabled the
  // restart beat is dropped and the FSM falls back to IDLE.
  assign start     = (state_q == StIdle) & pix_valid & pix_sof & cfg_enable;
  assign restart   = (state_q != StIdle) & pix_valid & pix_sof;
  assign abort     = restart & ~cfg_enable;
  assign low_beat  = start | (restart & cfg_enable) |
                     ((state_q == StLowHalf) & pix_valid & ~pix_sof);
  assign high_beat = (state_q == StHighHalf) & pix_valid & ~pix_sof;

  // FSM state register
  always_ff @(posedge sclk or negedge sclk_reset_n) begin
    if (!sclk_reset_n) state_q <= StIdle;
    else               state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else if (low_beat) begin
      if (pix_eof)      state_d = StIdle;
      else if (pix_eol) state_d = StLowHalf;
      else              state_d = StHighHalf;
    end else if (high_beat) begin
      state_d = pix_eof ? StIdle : StLowHalf;
    end
  end

  // FSM outputs: word assembly and push
  always_comb begin
    push        = 1'b0;
    push_entry  = '0;
    low_bytes_d = low_bytes_q;
    low_user_d  = low_user_q;
    if (low_beat) begin
      push             = pix_eol | pix_eof;
      push_entry.tdata = {32'h0, beat_bytes};
      push_entry.tuser = pix_sof;
      push_entry.tlast = 1'b1;
      low_bytes_d      = beat_bytes;
      low_user_d       = pix_sof;
    end else if (high_beat) begin
      push             = 1'b1;
      push_entry.tdata = {beat_bytes, low_bytes_q};
      push_entry.tuser = low_user_q;
      push_entry.tlast = pix_eol;
    end
  end

  // Line length counter: the current beat is included before the eol compare.
  always_comb begin
    cnt_base  = pix_sof ? '0 : pix_cnt_q;
    cnt_sum   = {1'b0, cnt_base} + (LPIX_W+1)'(4);
    cnt_beat  = cnt_sum[LPIX_W] ? '1 : cnt_sum[LPIX_W-1:0];
    pix_cnt_d = pix_cnt_q;
    len_bad   = 1'b0;
    if (abort) begin
      pix_cnt_d = '0;
    end else if (low_beat | high_beat) begin
      if (pix_eol) begin
        pix_cnt_d = '0;
        len_bad   = (cnt_beat != cfg_line_pix);
      end else begin
        pix_cnt_d = cnt_beat;
      end
    end
  end

  assign pop = ~fifo_empty & m_axis_tready;

  // Sticky flags: a new event in the clear cycle wins.
  always_comb begin
    overflow_d = overflow_q & ~stat_clr;
    len_err_d  = len_err_q & ~stat_clr;
    if (push & fifo_full & ~pop) overflow_d = 1'b1;
    if (len_bad | restart)       len_err_d  = 1'b1;
  end

  always_ff @(posedge sclk or negedge sclk_reset_n) begin
    if (!sclk_reset_n) begin
      low_bytes_q <= '0;
      low_user_q  <= 1'b0;
      pix_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      low_bytes_q <= low_bytes_d;
      low_user_q  <= low_user_d;
      pix_cnt_q   <= pix_cnt_d;
      overflow_q  <= overflow_d;
      len_err_q   <= len_err_d;
    end
  end

  xgs_sync_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (sclk),
    .rst_ni    (sclk_reset_n),
    .wr_en_i   (push),
    .wr_data_i (push_entry),
    .rd_en_i   (m_axis_tready),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign head_entry    = fifo_rdata;
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = head_entry.tdata;
  assign m_axis_tuser  = head_entry.tuser;
  assign m_axis_tlast  = head_entry.tlast;
  assign stat_overflow = overflow_q;
  assign stat_len_err  = len_err_q;

`ifdef XGS_LINE_PACKER_STATS_EN
  logic [15:0]       frame_cnt_q;
  logic [LPIX_W-1:0] line_cnt_q;

  always_ff @(posedge sclk or negedge sclk_reset_n) begin
    if (!sclk_reset_n) begin
      frame_cnt_q <= '0;
      line_cnt_q  <= '0;
    end else if (stat_clr) begin
      frame_cnt_q <= '0;
      line_cnt_q  <= '0;
    end else begin
      if (push & pix_eof) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (low_beat | high_beat) begin
        if (pix_sof)      line_cnt_q <= pix_eol ? LPIX_W'(1) : '0;
        else if (pix_eol) line_cnt_q <= line_cnt_q + LPIX_W'(1);
      end
    end
  end

  assign stat_frame_cnt = frame_cnt_q;
  assign stat_line_cnt  = line_cnt_q;
`endif

endmodule

// File: tb/tb_xgs_line_packer.sv
// Scoreboard bench for xgs_line_packer: stimulus pushes expected words into a queue, a
// negedge monitor pops and compares every accepted output word.
module tb_xgs_line_packer;
  import xgs_pkg::*;

  localparam int unsigned PIX_W  = 10;
  localparam int unsigned LPIX_W = 13;

  logic              sclk = 1'b0;
  logic              sclk_reset_n;
  logic              cfg_enable;
  logic [LPIX_W-1:0] cfg_line_pix;
  logic              pix_valid;
  logic [4*PIX_W-1:0] pix_data;
  logic              pix_sof, pix_eol, pix_eof;
  logic              m_axis_tvalid, m_axis_tready;
  logic [63:0]       m_axis_tdata;
  logic              m_axis_tuser, m_axis_tlast;
  logic              stat_overflow, stat_len_err, stat_clr;
`ifdef XGS_LINE_PACKER_STATS_EN
  logic [15:0]       stat_frame_cnt;
  logic [LPIX_W-1:0] stat_line_cnt;
`endif

  int checks = 0;
  int errors = 0;
  fifo_entry_t exp_q[$];
  fifo_entry_t mon_exp;

  always #5 sclk = ~sclk;

  xgs_line_packer #(
    .PIX_W      (PIX_W),
    .FIFO_DEPTH (4),
    .LPIX_W     (LPIX_W)
  ) dut (
    .sclk          (sclk),
    .sclk_reset_n  (sclk_reset_n),
    .cfg_enable    (cfg_enable),
    .cfg_line_pix  (cfg_line_pix),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_sof       (pix_sof),
    .pix_eol       (pix_eol),
    .pix_eof       (pix_eof),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .stat_overflow (stat_overflow),
    .stat_len_err  (stat_len_err),
    .stat_clr      (stat_clr)
`ifdef XGS_LINE_PACKER_STATS_EN
    ,
    .stat_frame_cnt (stat_frame_cnt),
    .stat_line_cnt  (stat_line_cnt)
`endif
  );

  // Monitor: every word accepted by the sink must match the scoreboard head.
  always @(negedge sclk) begin
    if (sclk_reset_n && m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream: unexpected word %h user %b last %b, required none",
                 m_axis_tdata, m_axis_tuser, m_axis_tlast);
      end else begin
        mon_exp = exp_q.pop_front();
        if (m_axis_tdata !== mon_exp.tdata || m_axis_tuser !== mon_exp.tuser ||
            m_axis_tlast !== mon_exp.tlast) begin
          errors++;
          $display("FAIL stream: got %h user %b last %b, required %h user %b last %b",
                   m_axis_tdata, m_axis_tuser, m_axis_tlast,
                   mon_exp.tdata, mon_exp.tuser, mon_exp.tlast);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [63:0] d, input logic u, input logic l);
    fifo_entry_t e;
    e.tdata = d;
    e.tuser = u;
    e.tlast = l;
    exp_q.push_back(e);
  endtask

  task automatic beat_raw(input logic [39:0] d, input logic sof, input logic eol,
                          input logic eof, input logic clr);
    @(posedge sclk);
    #1;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    pix_eol   = eol;
    pix_eof   = eof;
    stat_clr  = clr;
  endtask

  // Pixel k = {byte k, 2 junk LSBs}; only the byte should survive.
  task automatic beat(input logic [31:0] b, input logic sof, input logic eol, input logic eof,
                      input logic clr);
    beat_raw({b[31:24], 2'b01, b[23:16], 2'b10, b[15:8], 2'b11, b[7:0], 2'b00},
             sof, eol, eof, clr);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      pix_eol   = 1'b0;
      pix_eof   = 1'b0;
      stat_clr  = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(posedge sclk);
    #1 stat_clr = 1'b1;
    @(posedge sclk);
    #1 stat_clr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge sclk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sclk_reset_n  = 1'b0;
    cfg_enable    = 1'b1;
    cfg_line_pix  = 13'd16;
    pix_valid     = 1'b0;
    pix_data      = '0;
    pix_sof       = 1'b0;
    pix_eol       = 1'b0;
    pix_eof       = 1'b0;
    m_axis_tready = 1'b1;
    stat_clr      = 1'b0;
    repeat (3) @(negedge sclk);
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_tdata", m_axis_tdata, 0);
    chk("reset_tuser_tlast", {m_axis_tuser, m_axis_tlast}, 0);
    chk("reset_flags", {stat_overflow, stat_len_err}, 0);
    @(posedge sclk);
    #1 sclk_reset_n = 1'b1;

    // 16-pixel line, pixels 0x3FC down to 0x000 in steps of 0x44.
    expect_word(64'h8899AABB_CCDDEEFF, 1'b1, 1'b0);
    expect_word(64'h00112233_44556677, 1'b0, 1'b1);
    beat_raw({10'h330, 10'h374, 10'h3B8, 10'h3FC}, 1, 0, 0, 0);
    beat_raw({10'h220, 10'h264, 10'h2A8, 10'h2EC}, 0, 0, 0, 0);
    beat_raw({10'h110, 10'h154, 10'h198, 10'h1DC}, 0, 0, 0, 0);
    beat_raw({10'h000, 10'h044, 10'h088, 10'h0CC}, 0, 1, 1, 0);
    idle(1);
    drain("line16_drain");
    chk("line16_flags", {stat_overflow, stat_len_err}, 0);

    // 12-pixel line: odd beat count leaves a half word closed by eol.
    cfg_line_pix = 13'd12;
    expect_word(64'h08070605_04030201, 1'b1, 1'b0);
    expect_word(64'h00000000_3F7FBFFF, 1'b0, 1'b1);
    beat(32'h04030201, 1, 0, 0, 0);
    beat(32'h08070605, 0, 0, 0, 0);
    beat(32'h3F7FBFFF, 0, 1, 1, 0);
    idle(1);
    drain("line12_drain");
    chk("line12_len_err", stat_len_err, 0);

    // Stall: 6 words into a 4-deep FIFO, last two dropped.
    cfg_line_pix  = 13'd48;
    m_axis_tready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      expect_word({32'h01010101 * (2*j + 2), 32'h01010101 * (2*j + 1)}, j == 0, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      beat(32'h01010101 * (i + 1), i == 0, i == 11, i == 11, 0);
    end
    idle(1);
    @(negedge sclk);
    chk("stall_tvalid", m_axis_tvalid, 1);
    chk("stall_tdata_first", m_axis_tdata, 64'h02020202_01010101);
    chk("stall_overflow", stat_overflow, 1);
    repeat (3) @(negedge sclk);
    chk("stall_tdata_held", m_axis_tdata, 64'h02020202_01010101);
    @(posedge sclk);
    #1 m_axis_tready = 1'b1;
    drain("stall_drain");
    @(negedge sclk);
    chk("stall_empty", m_axis_tvalid, 0);

    // 20-pixel line against cfg 16, then clear, then clear colliding with a new error.
    cfg_line_pix = 13'd16;
    pulse_clr();
    @(negedge sclk);
    chk("clr_overflow", stat_overflow, 0);
    for (int r = 0; r < 2; r++) begin
      expect_word(64'h21222324_11121314, 1'b1, 1'b0);
      expect_word(64'h41424344_31323334, 1'b0, 1'b0);
      expect_word(64'h00000000_51525354, 1'b0, 1'b1);
      beat(32'h11121314, 1, 0, 0, 0);
      beat(32'h21222324, 0, 0, 0, 0);
      beat(32'h31323334, 0, 0, 0, 0);
      beat(32'h41424344, 0, 0, 0, 0);
      beat(32'h51525354, 0, 1, 1, r == 1);
      idle(1);
      @(negedge sclk);
      chk(r == 0 ? "len20_err" : "len20_clr_collide", stat_len_err, 1);
      if (r == 0) begin
        pulse_clr();
        @(negedge sclk);
        chk("len20_clr", stat_len_err, 0);
      end
    end
    drain("len20_drain");

    // sof restart after one beat: partial word vanishes.
    pulse_clr();
    cfg_line_pix = 13'd8;
    expect_word(64'hB4B3B2B1_A4A3A2A1, 1'b1, 1'b1);
    beat(32'hEEEEEEEE, 1, 0, 0, 0);
    beat(32'hA4A3A2A1, 1, 0, 0, 0);
    beat(32'hB4B3B2B1, 0, 1, 1, 0);
    idle(1);
    @(negedge sclk);
    chk("restart_len_err", stat_len_err, 1);
    drain("restart_drain");

    // Enable dropped mid-frame: frame still completes. Then sof while disabled: ignored.
    expect_word(64'hD4D3D2D1_C4C3C2C1, 1'b1, 1'b1);
    beat(32'hC4C3C2C1, 1, 0, 0, 0);
    beat(32'hD4D3D2D1, 0, 1, 1, 0);
    cfg_enable = 1'b0;
    idle(1);
    drain("enable_drop_drain");
    beat(32'h12345678, 1, 0, 0, 0);
    beat(32'h9ABCDEF0, 0, 1, 1, 0);
    idle(3);
    @(negedge sclk);
    chk("disabled_no_output", m_axis_tvalid, 0);
    cfg_enable = 1'b1;

    // Reset mid-frame with 2 words buffered.
    cfg_line_pix  = 13'd16;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) beat(32'h77777777, i == 0, 0, 0, 0);
    idle(1);
    @(negedge sclk);
    chk("prereset_tvalid", m_axis_tvalid, 1);
    #1 sclk_reset_n = 1'b0;
    #1;
    chk("reset_async_tvalid", m_axis_tvalid, 0);
    chk("reset_async_flags", {stat_overflow, stat_len_err}, 0);
`ifdef XGS_LINE_PACKER_STATS_EN
    chk("reset_frame_cnt", stat_frame_cnt, 0);
`endif
    @(posedge sclk);
    #1 sclk_reset_n = 1'b1;
    m_axis_tready = 1'b1;
    cfg_line_pix  = 13'd8;
    for (int f = 0; f < 3; f++) begin
      expect_word({32'h02020202 * (f + 1), 32'h01010101 * (f + 1)}, 1'b1, 1'b1);
      beat(32'h01010101 * (f + 1), 1, 0, 0, 0);
      beat(32'h02020202 * (f + 1), 0, 1, 1, 0);
    end
    idle(1);
    drain("postreset_drain");
    @(negedge sclk);
    chk("postreset_len_err", stat_len_err, 0);
`ifdef XGS_LINE_PACKER_STATS_EN
    chk("frame_cnt_3", stat_frame_cnt, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
